// File: rtl/lfsr_gen_pkg.sv
// lfsr_gen_pkg: shared types and constants for the lfsr_gen generator.
//   fsm_e      - control FSM states (IDLE, SKIP)
//   TAPS_W8/16/32 - maximal-length feedback masks for common widths
package lfsr_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } fsm_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_gen_step.sv
// lfsr_step: combinational one-step LFSR next-state function.
//   state_i - current state (WIDTH bits)
//   next_o  - state after one step
// GALOIS=0: Fibonacci, shift left with parity feedback into bit 0.
// GALOIS=1: Galois, shift right and XOR TAPS when the shifted-out bit is 1.
module lfsr_step #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
  parameter bit               GALOIS = 1'b0
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  generate
    if (GALOIS) begin : g_galois
      assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
    end else begin : g_fibonacci
      assign next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised seedable LFSR with single-step, skip-ahead and
// zero-seed protection.
//   clk, rst_n              - clock, asynchronous active-low reset
//   load_valid, load_seed   - load a seed (highest priority; aborts a skip)
//   step_en                 - advance one step while idle
//   adv_valid, adv_count    - skip-ahead request; adv_ready accepts it
//   adv_done                - pulse with the final state update of a skip
//   busy                    - skip in progress
//   seed_fixed              - pulse: a zero seed was replaced by RESET_SEED
//   lfsr_out                - current state
//   period_wrap, step_count - period tracking, only with LFSR_PERIOD_CNT_EN
//                             defined; tied to 0 otherwise
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_W8),
  parameter bit               GALOIS     = 1'b0,
  parameter logic [WIDTH-1:0] RESET_SEED = '1,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_seed,
  input  logic             step_en,
  input  logic             adv_valid,
  input  logic [CNT_W-1:0] adv_count,
  output logic             adv_ready,
  output logic             adv_done,
  output logic             busy,
  output logic             seed_fixed,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             period_wrap,
  output logic [WIDTH-1:0] step_count
);

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fixed_q, fixed_d;
  logic             do_step;
  logic [WIDTH-1:0] step_nxt;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .GALOIS(GALOIS)
  ) u_step (
    .state_i(state_q),
    .next_o (step_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= RESET_SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fixed_q <= fixed_d;
    end
  end

  // Next state: load > skip accept > single step
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fixed_d = 1'b0;
    do_step = 1'b0;
    if (load_valid) begin
      fsm_d = IDLE;
      if (load_seed == '0) begin
        state_d = RESET_SEED;
        fixed_d = 1'b1;
      end else begin
        state_d = load_seed;
      end
    end else begin
      case (fsm_q)
        IDLE: begin
          if (adv_valid) begin
            // Accept cycle never steps; a zero count completes immediately.
            if (adv_count == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d = adv_count;
              fsm_d = SKIP;
            end
          end else if (step_en) begin
            do_step = 1'b1;
          end
        end
        SKIP: begin
          do_step = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
        default: fsm_d = IDLE;
      endcase
      if (do_step) begin
        state_d = step_nxt;
      end
    end
  end

  assign adv_ready  = (fsm_q == IDLE) && !load_valid;
  assign busy       = (fsm_q == SKIP);
  assign adv_done   = done_q;
  assign seed_fixed = fixed_q;
  assign lfsr_out   = state_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] scnt_q, scnt_d;
  logic             wrap_q, wrap_d;

  // Period tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= RESET_SEED;
      scnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      seed_q <= seed_d;
      scnt_q <= scnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Wrap is detected on the post-step state against the last accepted seed
  always_comb begin
    seed_d = seed_q;
    scnt_d = scnt_q;
    wrap_d = 1'b0;
    if (load_valid) begin
      seed_d = state_d;
      scnt_d = '0;
    end else if (do_step) begin
      if (step_nxt == seed_q) begin
        wrap_d = 1'b1;
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + WIDTH'(1);
      end
    end
  end

  assign period_wrap = wrap_q;
  assign step_count  = scnt_q;
`else
  assign period_wrap = 1'b0;
  assign step_count  = '0;
`endif

endmodule
